ysyx_24110015_mem_arbiter: RTL and testbench
============================================

# ysyx_24110015_mem_arbiter

Shares the single memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write). One transaction is outstanding at a time. Arbitration is round-robin, and a timeout watchdog converts a hung memory response into an error response. Sits between IFU/LSU and the memory-access (DPI/AXI-lite bridge) block.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- TIMEOUT, 255, max cycles in WAIT before forced error response; must be ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  one-cycle response pulse to IFU
- ifu_rdata  out  DATA_W  fetched word
- ifu_rsp_err  out  1  error flag, valid with ifu_rsp_valid
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W  access address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte write mask
- lsu_rsp_valid, lsu_rdata, lsu_rsp_err  out  1/DATA_W/1  LSU response, same rules as IFU
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  downstream response
- mem_rdata  in  DATA_W  response data
- mem_rsp_err  in  1  downstream error

## Operation
- FSM states:
  - IDLE → REQ when a request handshakes.
  - REQ → WAIT on mem_req_valid && mem_req_ready.
  - WAIT → RESP on mem_rsp_valid, or when the timeout counter reaches TIMEOUT.
  - RESP → IDLE unconditionally.
- Grant in IDLE only:
  - x_req_ready = !rst && state==IDLE && grant_x (combinational).
  - Only one requester valid: grant it.
  - Both valid: grant the side selected by prio.
  - On any grant, prio flips to the non-granted side.
  - prio resets to IFU.
- On handshake, latch the owner and request fields into registers:
  - IFU grant: mem_wen=0, mem_wmask=0, mem_wdata=0.
  - mem_* outputs are driven only from these registers and stay stable through REQ.
- REQ: mem_req_valid=1 held until mem_req_ready. There is no timeout in REQ.
- WAIT:
  - The counter clears on entry and increments every cycle without mem_rsp_valid.
  - mem_rsp_valid latches mem_rdata and mem_rsp_err.
  - Timeout (counter == TIMEOUT) latches rdata=0, err=1.
- RESP: the owner's rsp_valid=1 for exactly one cycle with the latched rdata/err. The other side's rsp_valid=0.
  - LSU writes also produce a response; rdata is forwarded unmodified.
- mem_rsp_valid in any state other than WAIT (including a late response after timeout) is ignored.
- Requesters must accept a response in the cycle it is presented; there is no rsp_ready.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: state=IDLE, prio=IFU, all *_valid=0, *_ready=0, mem_* fields=0, rdata/err registers=0, counter=0.
- Reset asserted mid-transaction: immediate return to IDLE. The in-flight memory transaction is abandoned, and no response is issued for it after reset.
- Minimum latency, with ready and response both immediate:
  - Cycle 0: request handshake.
  - Cycle 1: mem_req_valid (accepted).
  - Cycle 2: mem_rsp_valid.
  - Cycle 3: rsp_valid.
  - Cycle 4: next request grant.
- Throughput: at most one transaction per 4 cycles.
- Timeout response: rsp_valid appears TIMEOUT+1 cycles after entering WAIT.
- A request arriving in any state other than IDLE sees ready=0 and must be held by the requester.

## Test plan
- Single IFU read, addr 0x80000000, mem returns 0x00000413 one cycle after accept → ifu_rsp_valid pulse at cycle 3 with rdata 0x00000413, err=0; lsu_rsp_valid stays 0.
- Both requesting continuously from reset → grants alternate IFU, LSU, IFU, LSU; each response goes only to its owner.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x3, mem_req_ready held low 5 cycles → mem_* stable for all 5 cycles; lsu_rsp_valid follows the memory response by 1 cycle.
- TIMEOUT=4, mem never responds → ifu_rsp_valid with err=1, rdata=0 exactly 5 cycles after WAIT entry; a late mem_rsp_valid is ignored and the FSM stays IDLE.
- rst pulsed during WAIT → all outputs 0 asynchronously; no stale response; the next grant goes to IFU.
- mem_rsp_err=1 on an LSU read → lsu_rsp_err=1, rdata forwarded, arbiter continues normally.

Source files
------------

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Memory-port arbiter: shares one downstream memory port between the
// instruction-fetch unit (read-only) and the load/store unit (read/write).
// One transaction is in flight at a time. Requests are granted round-robin
// in IDLE. A watchdog turns a hung memory response into an error response.
module ysyx_24110015_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch side
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_rsp_err,
  // load/store side
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_rsp_err,
  // downstream memory port
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {SIDE_IFU = 1'b0, SIDE_LSU = 1'b1} side_t;

  state_t            state, state_nxt;
  side_t             prio, owner;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              grant_ifu, grant_lsu;
  logic              handshake, timeout_hit;

  // Watchdog counter never wraps: it holds at its all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin choice: a lone requester wins, a tie goes to prio.
  always_comb begin
    grant_ifu = ifu_req_valid && (!lsu_req_valid || prio == SIDE_IFU);
    grant_lsu = lsu_req_valid && (!ifu_req_valid || prio == SIDE_LSU);
  end

  assign ifu_req_ready = !rst && (state == IDLE) && grant_ifu;
  assign lsu_req_ready = !rst && (state == IDLE) && grant_lsu;
  assign handshake     = ifu_req_ready || lsu_req_ready;
  assign timeout_hit   = (cnt == CNT_LIMIT);

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/response strobes.
  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    case (state)
      IDLE: if (handshake) state_nxt = REQ;
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: if (mem_rsp_valid || timeout_hit) state_nxt = RESP;
      RESP: begin
        ifu_rsp_valid = (owner == SIDE_IFU);
        lsu_rsp_valid = (owner == SIDE_LSU);
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch owner and request fields on grant; IFU reads carry no write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= SIDE_IFU;
      owner     <= SIDE_IFU;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (handshake) begin
      if (grant_ifu) begin
        owner     <= SIDE_IFU;
        prio      <= SIDE_LSU;
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
      end else begin
        owner     <= SIDE_LSU;
        prio      <= SIDE_IFU;
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
      end
    end
  end

  // Capture the memory response, or synthesise an error on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == WAIT) begin
      if (mem_rsp_valid) begin
        rdata_q <= mem_rdata;
        err_q   <= mem_rsp_err;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Watchdog: held at zero until WAIT, then counts idle WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               cnt <= '0;
    else if (state == REQ)                 cnt <= '0;
    else if (state == WAIT && !mem_rsp_valid) cnt <= sat_inc(cnt);
  end

  assign ifu_rdata   = rdata_q;
  assign ifu_rsp_err = err_q;
  assign lsu_rdata   = rdata_q;
  assign lsu_rsp_err = err_q;

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Self-checking bench for ysyx_24110015_mem_arbiter: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_ysyx_24110015_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;
  int last_win;  // side that won the most recent grant: 0 = IFU, 1 = LSU

  ysyx_24110015_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string where);
    check({where, "_ifu_ready"}, 32'(ifu_req_ready), 32'd0);
    check({where, "_lsu_ready"}, 32'(lsu_req_ready), 32'd0);
    check({where, "_ifu_rsp"},   32'(ifu_rsp_valid), 32'd0);
    check({where, "_lsu_rsp"},   32'(lsu_rsp_valid), 32'd0);
  endtask

  // One full transaction. Optionally raises new requests (a side already
  // waiting keeps its held request), predicts the winner, plays the memory
  // with the given accept/response delays and checks every cycle.
  task automatic do_txn(input bit new_i, input logic [31:0] ia,
                        input bit new_l, input logic [31:0] la, input bit lw,
                        input logic [31:0] lwd, input logic [3:0] lm,
                        input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rd, input bit re, input bit late);
    int win, nwait;
    logic [31:0] ea, ewd, erd;
    logic ew, ere;
    logic [3:0] em;
    @(negedge clk);
    if (new_i && !ifu_req_valid) begin ifu_req_valid = 1'b1; ifu_addr = ia; end
    if (new_l && !lsu_req_valid) begin
      lsu_req_valid = 1'b1; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
    end
    if (!ifu_req_valid && !lsu_req_valid) begin ifu_req_valid = 1'b1; ifu_addr = ia; end
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_rsp_valid = 1'($urandom_range(0, 1));
    mem_rdata     = $urandom;
    mem_rsp_err   = 1'($urandom_range(0, 1));
    if (ifu_req_valid && lsu_req_valid) win = (last_win == 0) ? 1 : 0;
    else                                win = ifu_req_valid ? 0 : 1;
    if (win == 0) begin ea = ifu_addr; ew = 1'b0; ewd = '0; em = '0; end
    else begin ea = lsu_addr; ew = lsu_wen; ewd = lsu_wdata; em = lsu_wmask; end
    #1;
    check("grant_ifu", 32'(ifu_req_ready), 32'(win == 0));
    check("grant_lsu", 32'(lsu_req_ready), 32'(win == 1));
    check("idle_mem_valid", 32'(mem_req_valid), 32'd0);
    check("idle_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
    check("idle_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
    last_win = win;
    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (win == 0) begin ifu_req_valid = 1'b0; ifu_addr = $urandom; end
        else begin
          lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom;
          lsu_wen = 1'($urandom_range(0, 1)); lsu_wmask = 4'($urandom);
        end
      end
      mem_req_ready = (k == rdy_dly);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      #1;
      check("req_valid", 32'(mem_req_valid), 32'd1);
      check("req_addr", mem_addr, ea);
      check("req_wen", 32'(mem_wen), 32'(ew));
      check("req_wdata", mem_wdata, ewd);
      check("req_wmask", 32'(mem_wmask), 32'(em));
      check_quiet("req");
    end
    nwait = (rsp_dly <= TMO) ? rsp_dly : TMO;
    for (int j = 0; j <= nwait; j++) begin
      @(negedge clk);
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = (j == rsp_dly);
      mem_rdata     = (j == rsp_dly) ? rd : $urandom;
      mem_rsp_err   = (j == rsp_dly) ? re : 1'($urandom_range(0, 1));
      #1;
      check("wait_mem_valid", 32'(mem_req_valid), 32'd0);
      check_quiet("wait");
    end
    if (rsp_dly <= TMO) begin erd = rd; ere = re; end
    else begin erd = '0; ere = 1'b1; end
    @(negedge clk);
    mem_rsp_valid = late;
    mem_rdata     = $urandom;
    mem_rsp_err   = 1'b1;
    #1;
    check("rsp_ifu_valid", 32'(ifu_rsp_valid), 32'(win == 0));
    check("rsp_lsu_valid", 32'(lsu_rsp_valid), 32'(win == 1));
    check("rsp_mem_valid", 32'(mem_req_valid), 32'd0);
    if (win == 0) begin
      check("ifu_rdata", ifu_rdata, erd);
      check("ifu_err", 32'(ifu_rsp_err), 32'(ere));
    end else begin
      check("lsu_rdata", lsu_rdata, erd);
      check("lsu_err", 32'(lsu_rsp_err), 32'(ere));
    end
  endtask

  // Idle cycles with a stray memory response: nothing may move.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rdata     = $urandom;
      #1;
      check("idle_stray_mem_valid", 32'(mem_req_valid), 32'd0);
      check_quiet("idle_stray");
    end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
    last_win = 1;

    // reset state, with a request present that must not be accepted
    repeat (2) @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    check("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst_rdata", ifu_rdata, 32'd0);
    check("rst_err", 32'(lsu_rsp_err), 32'd0);
    check_quiet("rst");
    @(negedge clk);
    ifu_req_valid = 1'b0;
    rst = 1'b0;

    // single IFU read, minimum latency
    do_txn(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, '0, 0, 0, 32'h0000_0413, 1'b0, 1'b0);
    // both requesting continuously: alternating grants
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 32'h8000_0100 + 32'(i * 4), 1'b1, 32'h8000_0200 + 32'(i * 4),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom), 0, 1, $urandom, 1'b0, 1'b0);
    do_txn(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 0, 0, $urandom, 1'b0, 1'b0);
    // LSU write with memory stalling its accept for 5 cycles
    do_txn(1'b0, '0, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 5, 0,
           32'h1234_5678, 1'b0, 1'b0);
    // memory never answers: forced error, late response ignored
    do_txn(1'b1, 32'h8000_0040, 1'b0, '0, 1'b0, '0, '0, 0, 100, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle_cycles(3);
    // memory error on an LSU read, then carry on
    do_txn(1'b0, '0, 1'b1, 32'h8000_2000, 1'b0, '0, '0, 1, 2, 32'hCAFE_F00D, 1'b1, 1'b0);
    do_txn(1'b1, 32'h8000_0044, 1'b0, '0, 1'b0, '0, '0, 0, 0, 32'h0000_0013, 1'b0, 1'b0);

    // reset pulsed while waiting for the memory response
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_3000; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000;
    #1;
    check("arst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check_quiet("arst");
    @(negedge clk);
    lsu_req_valid = 1'b0;
    rst = 1'b0;
    last_win = 1;
    idle_cycles(3);
    do_txn(1'b1, 32'h8000_5000, 1'b1, 32'h8000_6000, 1'b0, '0, '0, 0, 0,
           32'h0BAD_CAFE, 1'b0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 150; t++)
      do_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
             1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
             $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 6),
             $urandom, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
